control_unit: RTL and testbench
===============================

# control_unit

Instruction-sequencing state machine for the RISC SPM processor. It is the driving side of the ALU opcode/zero-flag interface: it issues the ALU opcode, decides when the ALU result is captured, and consumes the registered zero flag for conditional branches. It also generates every load/select strobe for the register file, PC, IR, address register, Reg_Y, Reg_Z and the memory write.

## Interface
Parameters: none; 8-bit datapath, 4-bit opcode, 2-bit register fields fixed.
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- instruction  input  8  IR contents; [7:4] opcode, [3:2] src, [1:0] dest
- zero  input  1  registered ALU zero flag (Reg_Z)
- alu_sel  output  4  ALU opcode (NOP=0000, ADD=0001, SUB=0010, AND=0011, NOT=0100)
- load_r0, load_r1, load_r2, load_r3  output  1 each  register-file load strobes
- load_pc, inc_pc  output  1 each  PC load from Bus_2 / PC increment
- load_ir, load_add_r, load_reg_y, load_reg_z  output  1 each  IR / address / Reg_Y / Reg_Z load strobes
- sel_bus1  output  3  Bus_1 source: 0..3 = R0..R3, 4 = PC, 5..7 unused
- sel_bus2  output  2  Bus_2 source: 0 = ALU_out, 1 = Bus_1, 2 = memory, 3 unused
- write  output  1  memory write strobe
- halted  output  1  high while in HALT

## Operation
- States: IDLE, FET1, FET2, DEC, EX1, RD1, RD2, WR1, WR2, BR1, BR2, HALT; 4-bit registered state.
- Outputs are combinational from state and instruction. Defaults in every state: all strobes 0, sel_bus1=0, sel_bus2=0, alu_sel=0000, halted=0.
- "dest load" = the load_rN selected by instruction[1:0]; "src" = instruction[3:2].
- IDLE: all outputs at defaults; next state FET1.
- FET1: sel_bus1=4, sel_bus2=1, load_add_r; next state FET2.
- FET2: sel_bus2=2, load_ir, inc_pc; next state DEC.
- DEC, dispatched on opcode:
  - NOP (0000): no strobes; next state FET1.
  - ADD/SUB/AND: sel_bus1=src, sel_bus2=1, load_reg_y; next state EX1.
  - NOT (0100): alu_sel=0100, sel_bus1=src, sel_bus2=0, load_reg_z, dest load; next state FET1.
  - RD (0101), WR (0110), BR (0111): sel_bus1=4, sel_bus2=1, load_add_r; next state RD1 / WR1 / BR1 respectively.
  - BRZ (1000), zero=1: same strobes as BR; next state BR1.
  - BRZ (1000), zero=0: inc_pc only, skipping the address byte; next state FET1.
  - Opcodes 1001–1111: no strobes; next state HALT.
- EX1: alu_sel=opcode, sel_bus1=dest, sel_bus2=0, load_reg_z, dest load; next state FET1.
- RD1: sel_bus2=2, load_add_r, inc_pc; next state RD2.
- RD2: sel_bus2=2, dest load; next state FET1.
- WR1: sel_bus2=2, load_add_r, inc_pc; next state WR2.
- WR2: sel_bus1=src, write; next state FET1.
- BR1: sel_bus2=2, load_add_r; next state BR2.
- BR2: sel_bus2=2, load_pc; next state FET1.
- HALT: halted=1, no other strobes; remains in HALT until rst.
- alu_sel is non-NOP only in DEC(NOT) and EX1. Reg_Z therefore updates only on NOT, ADD, SUB and AND.
- dest == src is legal; for example, ADD R1,R1 doubles R1.

## Timing
- rst asserted: state=IDLE immediately, with no clock edge needed; all outputs return to defaults combinationally.
- After rst deasserts, the first rising edge enters FET1.
- Clocks per instruction, FET1 through the last state: NOP 3, NOT 3, ADD/SUB/AND 4, RD 5, WR 5, BR 5, BRZ taken 5, BRZ not-taken 3.
- Strobes are valid for exactly one clock. The datapath captures them on the rising edge that leaves the state.
- zero is sampled only in DEC. Its value at that edge decides BRZ.
- Reset asserted mid-instruction (any state) aborts the instruction. No partial strobe may persist.

## Test plan
- Reset: hold rst=1 for 2 clocks -> state IDLE, all outputs 0. Release -> FET1 on next edge with sel_bus1=4, sel_bus2=1, load_add_r=1.
- ADD, instruction=0x16 (src R1, dest R2): FET1, FET2, DEC with load_reg_y=1 and sel_bus1=1, then EX1 with alu_sel=0001, sel_bus1=2, sel_bus2=0, load_r2=1, load_reg_z=1. Back to FET1 after 4 clocks.
- NOT, instruction=0x4C (src R3, dest R0): in DEC, alu_sel=0100, sel_bus1=3, load_r0=1, load_reg_z=1. Next state FET1.
- BRZ, instruction=0x80: with zero=0, DEC asserts inc_pc only and returns to FET1 in 3 clocks. With zero=1, sequence BR1 then BR2, with load_pc=1 in BR2.
- RD 0x53 then WR 0x64: RD2 asserts load_r3 with sel_bus2=2. WR2 asserts write=1 with sel_bus1=1. Each takes 5 clocks.
- Illegal opcode: instruction=0xF0 -> HALT with halted=1, no strobes for 10+ clocks. Then pulse rst mid-RD1 -> IDLE immediately, before any clock edge.

Source files
------------

// File: rtl/control_unit.sv
// Instruction-sequencing FSM for the RISC SPM processor: walks fetch/decode/execute
// and drives every datapath strobe combinationally from the current state and IR.
module control_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] instruction,
    input  logic       zero,
    output logic [3:0] alu_sel,
    output logic       load_r0,
    output logic       load_r1,
    output logic       load_r2,
    output logic       load_r3,
    output logic       load_pc,
    output logic       inc_pc,
    output logic       load_ir,
    output logic       load_add_r,
    output logic       load_reg_y,
    output logic       load_reg_z,
    output logic [2:0] sel_bus1,
    output logic [1:0] sel_bus2,
    output logic       write,
    output logic       halted
);

    typedef enum logic [3:0] {
        StIdle = 4'd0,
        StFet1 = 4'd1,
        StFet2 = 4'd2,
        StDec  = 4'd3,
        StEx1  = 4'd4,
        StRd1  = 4'd5,
        StRd2  = 4'd6,
        StWr1  = 4'd7,
        StWr2  = 4'd8,
        StBr1  = 4'd9,
        StBr2  = 4'd10,
        StHalt = 4'd11
    } state_e;

    localparam logic [3:0] OpNop = 4'h0;
    localparam logic [3:0] OpAdd = 4'h1;
    localparam logic [3:0] OpSub = 4'h2;
    localparam logic [3:0] OpAnd = 4'h3;
    localparam logic [3:0] OpNot = 4'h4;
    localparam logic [3:0] OpRd  = 4'h5;
    localparam logic [3:0] OpWr  = 4'h6;
    localparam logic [3:0] OpBr  = 4'h7;
    localparam logic [3:0] OpBrz = 4'h8;

    localparam logic [2:0] Bus1Pc   = 3'd4;
    localparam logic [1:0] Bus2Alu  = 2'd0;
    localparam logic [1:0] Bus2Bus1 = 2'd1;
    localparam logic [1:0] Bus2Mem  = 2'd2;

    state_e     state_q, state_d;
    logic [3:0] opcode;
    logic [1:0] src, dest;
    logic [3:0] dest_load;
    logic [3:0] load_r;

    assign opcode    = instruction[7:4];
    assign src       = instruction[3:2];
    assign dest      = instruction[1:0];
    assign dest_load = 4'b0001 << dest;

    assign load_r0 = load_r[0];
    assign load_r1 = load_r[1];
    assign load_r2 = load_r[2];
    assign load_r3 = load_r[3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: state_d = StFet1;
            StFet1: state_d = StFet2;
            StFet2: state_d = StDec;
            StDec: begin
                case (opcode)
                    OpNop:               state_d = StFet1;
                    OpAdd, OpSub, OpAnd: state_d = StEx1;
                    OpNot:               state_d = StFet1;
                    OpRd:                state_d = StRd1;
                    OpWr:                state_d = StWr1;
                    OpBr:                state_d = StBr1;
                    OpBrz:               state_d = zero ? StBr1 : StFet1;
                    default:             state_d = StHalt;
                endcase
            end
            StEx1:  state_d = StFet1;
            StRd1:  state_d = StRd2;
            StRd2:  state_d = StFet1;
            StWr1:  state_d = StWr2;
            StWr2:  state_d = StFet1;
            StBr1:  state_d = StBr2;
            StBr2:  state_d = StFet1;
            StHalt: state_d = StHalt;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        alu_sel    = OpNop;
        load_r     = '0;
        load_pc    = 1'b0;
        inc_pc     = 1'b0;
        load_ir    = 1'b0;
        load_add_r = 1'b0;
        load_reg_y = 1'b0;
        load_reg_z = 1'b0;
        sel_bus1   = 3'd0;
        sel_bus2   = Bus2Alu;
        write      = 1'b0;
        halted     = 1'b0;
        case (state_q)
            StFet1: begin
                sel_bus1   = Bus1Pc;
                sel_bus2   = Bus2Bus1;
                load_add_r = 1'b1;
            end
            StFet2: begin
                sel_bus2 = Bus2Mem;
                load_ir  = 1'b1;
                inc_pc   = 1'b1;
            end
            StDec: begin
                case (opcode)
                    OpAdd, OpSub, OpAnd: begin
                        sel_bus1   = {1'b0, src};
                        sel_bus2   = Bus2Bus1;
                        load_reg_y = 1'b1;
                    end
                    OpNot: begin
                        alu_sel    = OpNot;
                        sel_bus1   = {1'b0, src};
                        sel_bus2   = Bus2Alu;
                        load_reg_z = 1'b1;
                        load_r     = dest_load;
                    end
                    OpRd, OpWr, OpBr: begin
                        sel_bus1   = Bus1Pc;
                        sel_bus2   = Bus2Bus1;
                        load_add_r = 1'b1;
                    end
                    OpBrz: begin
                        if (zero) begin
                            sel_bus1   = Bus1Pc;
                            sel_bus2   = Bus2Bus1;
                            load_add_r = 1'b1;
                        end else begin
                            // Not taken: step the PC past the branch-target byte.
                            inc_pc = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            StEx1: begin
                alu_sel    = opcode;
                sel_bus1   = {1'b0, dest};
                sel_bus2   = Bus2Alu;
                load_reg_z = 1'b1;
                load_r     = dest_load;
            end
            StRd1, StWr1: begin
                sel_bus2   = Bus2Mem;
                load_add_r = 1'b1;
                inc_pc     = 1'b1;
            end
            StRd2: begin
                sel_bus2 = Bus2Mem;
                load_r   = dest_load;
            end
            StWr2: begin
                sel_bus1 = {1'b0, src};
                write    = 1'b1;
            end
            StBr1: begin
                sel_bus2   = Bus2Mem;
                load_add_r = 1'b1;
            end
            StBr2: begin
                sel_bus2 = Bus2Mem;
                load_pc  = 1'b1;
            end
            StHalt: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Randomized bench for control_unit: each instruction is expanded by a transaction-level
// model into its expected per-clock strobe pattern and compared cycle by cycle.
module tb_control_unit;

    typedef struct packed {
        logic [3:0] alu;
        logic [3:0] ld_r;
        logic       ld_pc;
        logic       inc_pc;
        logic       ld_ir;
        logic       ld_add;
        logic       ld_y;
        logic       ld_z;
        logic [2:0] b1;
        logic [1:0] b2;
        logic       wr;
        logic       halt;
    } ov_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] instruction;
    logic       zero;
    logic [3:0] alu_sel;
    logic       load_r0, load_r1, load_r2, load_r3;
    logic       load_pc, inc_pc, load_ir, load_add_r, load_reg_y, load_reg_z;
    logic [2:0] sel_bus1;
    logic [1:0] sel_bus2;
    logic       write, halted;

    ov_t         obs;
    ov_t         exp_q[$];
    bit          exp_halts;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    control_unit dut (
        .clk        (clk),
        .rst        (rst),
        .instruction(instruction),
        .zero       (zero),
        .alu_sel    (alu_sel),
        .load_r0    (load_r0),
        .load_r1    (load_r1),
        .load_r2    (load_r2),
        .load_r3    (load_r3),
        .load_pc    (load_pc),
        .inc_pc     (inc_pc),
        .load_ir    (load_ir),
        .load_add_r (load_add_r),
        .load_reg_y (load_reg_y),
        .load_reg_z (load_reg_z),
        .sel_bus1   (sel_bus1),
        .sel_bus2   (sel_bus2),
        .write      (write),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    assign obs = {alu_sel, load_r3, load_r2, load_r1, load_r0, load_pc, inc_pc, load_ir,
                  load_add_r, load_reg_y, load_reg_z, sel_bus1, sel_bus2, write, halted};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%06h expected 0x%06h", tag, got, exp);
    endtask

    // Expected clock-by-clock outputs of one instruction, FET1 through its last state.
    task automatic model(input logic [7:0] ins, input logic z);
        ov_t        o;
        int         op;
        logic [3:0] dmask;
        logic [2:0] src, dst;
        op        = int'(ins[7:4]);
        dmask     = 4'b0000;
        dmask[ins[1:0]] = 1'b1;
        src       = {1'b0, ins[3:2]};
        dst       = {1'b0, ins[1:0]};
        exp_halts = 1'b0;
        exp_q.delete();
        o = '0; o.b1 = 3'd4; o.b2 = 2'd1; o.ld_add = 1'b1; exp_q.push_back(o);
        o = '0; o.b2 = 2'd2; o.ld_ir = 1'b1; o.inc_pc = 1'b1; exp_q.push_back(o);
        if (op == 0) begin
            exp_q.push_back('0);
        end else if (op >= 1 && op <= 3) begin
            o = '0; o.b1 = src; o.b2 = 2'd1; o.ld_y = 1'b1; exp_q.push_back(o);
            o = '0; o.alu = 4'(op); o.b1 = dst; o.ld_z = 1'b1; o.ld_r = dmask;
            exp_q.push_back(o);
        end else if (op == 4) begin
            o = '0; o.alu = 4'd4; o.b1 = src; o.ld_z = 1'b1; o.ld_r = dmask;
            exp_q.push_back(o);
        end else if (op == 8 && !z) begin
            o = '0; o.inc_pc = 1'b1; exp_q.push_back(o);
        end else if (op >= 5 && op <= 8) begin
            o = '0; o.b1 = 3'd4; o.b2 = 2'd1; o.ld_add = 1'b1; exp_q.push_back(o);
            o = '0; o.b2 = 2'd2; o.ld_add = 1'b1; o.inc_pc = (op == 5 || op == 6);
            exp_q.push_back(o);
            o = '0;
            if (op == 5) begin o.b2 = 2'd2; o.ld_r = dmask; end
            else if (op == 6) begin o.b1 = src; o.wr = 1'b1; end
            else begin o.b2 = 2'd2; o.ld_pc = 1'b1; end
            exp_q.push_back(o);
        end else begin
            exp_q.push_back('0);
            exp_halts = 1'b1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered 1 time unit after a rising edge; leaves the DUT 1 unit into FET1.
    task automatic do_reset(input string tag);
        #1 rst = 1'b1;
        #1 check_eq({tag, "_rst_async"}, obs, '0);
        repeat (2) @(posedge clk);
        #1 check_eq({tag, "_rst_idle"}, obs, '0);
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic run_instr(input logic [7:0] ins, input logic z, input int abort_at);
        ov_t o;
        instruction = ins;
        zero        = z;
        model(ins, z);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i == abort_at) begin
                do_reset($sformatf("i%02h_abort%0d", ins, i));
                return;
            end
            check_eq($sformatf("i%02h_z%0d_c%0d", ins, z, i), obs, exp_q[i]);
            step();
        end
        if (exp_halts) begin
            o = '0; o.halt = 1'b1;
            for (int i = 0; i < 12; i++) begin
                check_eq($sformatf("i%02h_halt%0d", ins, i), obs, o);
                step();
            end
            do_reset($sformatf("i%02h_halt", ins));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] ins;
        logic       z;
        int         abort_at;
        rst         = 1'b1;
        instruction = 8'h00;
        zero        = 1'b0;
        do_reset("init");

        run_instr(8'h16, 1'b0, -1);
        run_instr(8'h4C, 1'b1, -1);
        run_instr(8'h80, 1'b0, -1);
        run_instr(8'h80, 1'b1, -1);
        run_instr(8'h53, 1'b0, -1);
        run_instr(8'h64, 1'b1, -1);
        run_instr(8'h55, 1'b0, -1);
        run_instr(8'hF0, 1'b0, -1);
        run_instr(8'h53, 1'b0, 3);

        for (int n = 0; n < 400; n++) begin
            ins = 8'($urandom);
            if ($urandom_range(0, 3) != 0) ins[7:4] = 4'($urandom_range(0, 8));
            z = 1'($urandom);
            abort_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : -1;
            run_instr(ins, z, abort_at);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
